// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family of blocks.
//   cnt_op_t      : 2-bit command opcode (INC, DEC, CLEAR, LOAD)
//   TICK_PEND_MAX : depth of the autocount tick queue
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        OP_INC   = 2'b00,
        OP_DEC   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_LOAD  = 2'b11
    } cnt_op_t;

    localparam int TICK_PEND_MAX = 3;

endpackage

// File: rtl/counter_arbiter_if.sv
// ----------------------------------------------------------------------------
// counter_arbiter_if
// Command bus between N_REQ requesters and the shared counter.
//   req_valid [N_REQ]       : per-requester command valid, held until accepted
//   req_op    [2*N_REQ]     : opcode, slice i at [2i+:2]
//   req_data  [CNT_W*N_REQ] : LOAD value, slice i at [CNT_W*i+:CNT_W]
//   req_ready [N_REQ]       : one-hot accept from the counter
// master = requester side, slave = counter side.
// ----------------------------------------------------------------------------
interface counter_arbiter_if
    import counter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);

    logic [N_REQ-1:0]       req_valid;
    logic [2*N_REQ-1:0]     req_op;
    logic [CNT_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_op,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter.
//   valid     [N]     : request lines
//   ptr       [IDX_W] : index of the last granted requester
//   grant     [N]     : one-hot grant
//   grant_idx [IDX_W] : index of the granted requester
//   grant_vld         : any grant this cycle
// The search starts at ptr+1 and wraps, so the last winner has lowest
// priority on the next cycle.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!grant_vld && valid[cand]) begin
                grant_vld   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// ----------------------------------------------------------------------------
// counter_arbiter
// One CNT_W-bit event counter shared between N_REQ command requesters
// (round-robin) and a divided-clock autocount tick (queued up to 3 deep).
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : req_valid / req_op / req_data / req_ready
//   tick_en, tick_div  : autocount enable and divider reload (period div+1)
//   clr_err            : clears the sticky tick_lost flag
//   count              : registered counter value
//   cnt_zero_p         : pulse when count becomes 0
//   cnt_max_p          : pulse when count becomes all-ones
//   wrap_p             : pulse on INC/tick max->0 or DEC 0->max
//   tick_pend          : queued ticks (0..3)
//   tick_lost          : sticky, a tick was dropped on a full queue
// ----------------------------------------------------------------------------
module counter_arbiter
    import counter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 24
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    counter_arbiter_if.slave   bus,
    input  logic               tick_en,
    input  logic [DIV_W-1:0]   tick_div,
    input  logic               clr_err,
    output logic [CNT_W-1:0]   count,
    output logic               cnt_zero_p,
    output logic               cnt_max_p,
    output logic               wrap_p,
    output logic [1:0]         tick_pend,
    output logic               tick_lost
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;

    logic [DIV_W-1:0] div;
    logic             new_tick;
    logic             apply_tick;

    cnt_op_t          gnt_op;
    logic [CNT_W-1:0] gnt_data;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             cnt_chg;

    logic [2:0]       pend_sum;
    logic             tick_drop;
    logic [1:0]       pend_nxt;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    // No command may be accepted while reset is held.
    assign bus.req_ready = sys_rst_n ? gnt : '0;

    // Select the winner's opcode and operand.
    always_comb begin
        gnt_op   = OP_INC;
        gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_op   = cnt_op_t'(bus.req_op[2*i +: 2]);
                gnt_data = bus.req_data[CNT_W*i +: CNT_W];
            end
        end
    end

    assign new_tick   = tick_en && (div == '0);
    // Queued ticks only use cycles the requesters leave idle.
    assign apply_tick = !gnt_vld && (tick_pend != 2'd0);

    always_comb begin
        cnt_nxt  = count;
        wrap_nxt = 1'b0;
        if (gnt_vld) begin
            case (gnt_op)
                OP_INC: begin
                    cnt_nxt  = count + 1'b1;
                    wrap_nxt = (count == '1);
                end
                OP_DEC: begin
                    cnt_nxt  = count - 1'b1;
                    wrap_nxt = (count == '0);
                end
                OP_CLEAR: cnt_nxt = '0;
                OP_LOAD:  cnt_nxt = gnt_data;
                default:  cnt_nxt = count;
            endcase
        end else if (apply_tick) begin
            cnt_nxt  = count + 1'b1;
            wrap_nxt = (count == '1);
        end
    end

    // Pulses only mark real transitions of the count.
    assign cnt_chg = (cnt_nxt != count);

    // A sum of 4 can only come from a new tick on a full queue with nothing
    // drained: that tick is dropped.
    assign pend_sum  = {1'b0, tick_pend} + {2'b00, new_tick} - {2'b00, apply_tick};
    assign tick_drop = (pend_sum > 3'(TICK_PEND_MAX));
    assign pend_nxt  = tick_drop ? 2'(TICK_PEND_MAX) : pend_sum[1:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count      <= '0;
            div        <= '0;
            rr_ptr     <= IDX_W'(N_REQ - 1);
            tick_pend  <= 2'd0;
            tick_lost  <= 1'b0;
            cnt_zero_p <= 1'b0;
            cnt_max_p  <= 1'b0;
            wrap_p     <= 1'b0;
        end else begin
            count <= cnt_nxt;

            if (!tick_en || (div == '0)) begin
                div <= tick_div;
            end else begin
                div <= div - 1'b1;
            end

            if (gnt_vld) begin
                rr_ptr <= gnt_idx;
            end

            tick_pend <= pend_nxt;
            // A drop wins over a simultaneous clear request.
            if (tick_drop) begin
                tick_lost <= 1'b1;
            end else if (clr_err) begin
                tick_lost <= 1'b0;
            end

            cnt_zero_p <= cnt_chg && (cnt_nxt == '0);
            cnt_max_p  <= cnt_chg && (cnt_nxt == '1);
            wrap_p     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// ----------------------------------------------------------------------------
// tb_counter_arbiter
// Self-checking bench for counter_arbiter with an abstract reference model.
// ----------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;
    localparam int DIV_W = 24;
    localparam int M     = 256;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             tick_en;
    logic [DIV_W-1:0] tick_div;
    logic             clr_err;
    logic [CNT_W-1:0] count;
    logic             cnt_zero_p;
    logic             cnt_max_p;
    logic             wrap_p;
    logic [1:0]       tick_pend;
    logic             tick_lost;

    counter_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    counter_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .bus        (bus),
        .tick_en    (tick_en),
        .tick_div   (tick_div),
        .clr_err    (clr_err),
        .count      (count),
        .cnt_zero_p (cnt_zero_p),
        .cnt_max_p  (cnt_max_p),
        .wrap_p     (wrap_p),
        .tick_pend  (tick_pend),
        .tick_lost  (tick_lost)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_count, m_div, m_ptr, m_pend;
    bit m_lost, m_zp, m_mp, m_wp;

    task automatic model_reset();
        m_count = 0; m_div = 0; m_ptr = N_REQ - 1; m_pend = 0;
        m_lost = 0; m_zp = 0; m_mp = 0; m_wp = 0;
    endtask

    // Next requester after the last winner, going round the ring.
    function automatic int model_grant();
        for (int k = 1; k <= N_REQ; k++) begin
            if (bus.req_valid[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] exp_ready();
        int g;
        g = model_grant();
        if (g < 0) return '0;
        return N_REQ'(1 << g);
    endfunction

    function automatic logic [13:0] obs_status();
        return {count, cnt_zero_p, cnt_max_p, wrap_p, tick_pend, tick_lost};
    endfunction

    function automatic logic [13:0] exp_status();
        return {CNT_W'(m_count), m_zp, m_mp, m_wp, 2'(m_pend), m_lost};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic clk_step();
        int g, op, data, nc, tot;
        bit nt, at, wr;
        g  = model_grant();
        nt = tick_en && (m_div == 0);
        at = (g < 0) && (m_pend > 0);
        nc = m_count;
        wr = 0;
        if (g >= 0) begin
            op   = int'((bus.req_op >> (2 * g)) & 8'h3);
            data = int'((bus.req_data >> (CNT_W * g)) & 32'hFF);
            case (op)
                0: begin nc = (m_count + 1) % M;     wr = (m_count == M - 1); end
                1: begin nc = (m_count + M - 1) % M; wr = (m_count == 0);     end
                2: nc = 0;
                default: nc = data;
            endcase
            m_ptr = g;
        end else if (at) begin
            nc = (m_count + 1) % M;
            wr = (m_count == M - 1);
        end
        m_zp = (nc != m_count) && (nc == 0);
        m_mp = (nc != m_count) && (nc == M - 1);
        m_wp = wr;
        m_count = nc;
        m_div = (!tick_en || m_div == 0) ? int'(tick_div) : m_div - 1;
        tot = m_pend + int'(nt) - int'(at);
        if (tot > 3) begin
            tot = 3;
            m_lost = 1;
        end else if (clr_err) begin
            m_lost = 0;
        end
        m_pend = tot;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        tick_en       = 1'b0;
        clr_err       = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        idle_inputs();
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        tick_div = 24'd1;
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = 4'($urandom);
            bus.req_op    = 8'h00;
            tick_en       = 1'b1;
            #1;
            n_checks++;
            if (bus.req_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL reset_prerun_ready: got %b expected %b", bus.req_ready, exp_ready());
            end
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL reset_prerun_status: got %h expected %h", obs_status(), exp_status());
            end
        end
        // Assert reset between edges with requests pending.
        @(negedge sys_clk);
        bus.req_valid = '1;
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_status() !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_async_status: got %h expected %h", obs_status(), 14'h0);
        end
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b expected 0000", bus.req_ready);
        end
        @(posedge sys_clk);
        #1;
        n_checks++;
        if (count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_no_accept: got %h expected 00", count);
        end
        @(negedge sys_clk);
        idle_inputs();
        sys_rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            clk_step();
            n_checks++;
            if (count !== 8'h00 || obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL reset_hold_zero: got %h expected %h", obs_status(), exp_status());
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 4'hF;
            bus.req_op    = 8'h00;
            #1;
            n_checks++;
            if (bus.req_ready !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %b expected %b", k, bus.req_ready, 4'(1 << (k % 4)));
            end
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL rr_status: got %h expected %h", obs_status(), exp_status());
            end
        end
        n_checks++;
        if (count !== 8'd8) begin
            n_fail++;
            $display("FAIL rr_final_count: got %0d expected 8", count);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        // LOAD 0xFF on requester 1
        bus.req_valid = 4'b0010; bus.req_op = 8'b0000_1100; bus.req_data = 32'h0000_FF00;
        clk_step();
        n_checks++;
        if ({count, cnt_max_p, wrap_p} !== {8'hFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_load: got %h/%b/%b expected ff/1/0", count, cnt_max_p, wrap_p);
        end
        // INC on requester 2
        bus.req_valid = 4'b0100; bus.req_op = 8'h00;
        clk_step();
        n_checks++;
        if ({count, wrap_p, cnt_zero_p, cnt_max_p} !== {8'h00, 3'b110}) begin
            n_fail++;
            $display("FAIL wrap_inc: got %h/%b%b%b expected 00/110", count, wrap_p, cnt_zero_p, cnt_max_p);
        end
        // DEC on requester 3
        bus.req_valid = 4'b1000; bus.req_op = 8'b0100_0000;
        clk_step();
        n_checks++;
        if ({count, wrap_p, cnt_zero_p, cnt_max_p} !== {8'hFF, 3'b101}) begin
            n_fail++;
            $display("FAIL wrap_dec: got %h/%b%b%b expected ff/101", count, wrap_p, cnt_zero_p, cnt_max_p);
        end
        // LOAD of the same value: no transition, no pulses
        bus.req_valid = 4'b0001; bus.req_op = 8'b0000_0011; bus.req_data = 32'h0000_00FF;
        clk_step();
        n_checks++;
        if ({count, wrap_p, cnt_zero_p, cnt_max_p} !== {8'hFF, 3'b000} || obs_status() !== exp_status()) begin
            n_fail++;
            $display("FAIL wrap_load_same: got %h expected %h", obs_status(), exp_status());
        end
        idle_inputs();
    endtask

    task automatic test_tick_queue();
        // Reload divider to 0 and clear the count
        tick_div = 24'd0;
        bus.req_valid = 4'b0001; bus.req_op = 8'b0000_0010;
        clk_step();
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 4'b0001; bus.req_op = 8'h00;
            tick_en = 1'b1;
            clr_err = (k == 4);
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL tq_fill[%0d]: got %h expected %h", k, obs_status(), exp_status());
            end
        end
        n_checks++;
        if ({count, tick_pend, tick_lost} !== {8'd5, 2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL tq_saturate: got %0d/%0d/%b expected 5/3/1", count, tick_pend, tick_lost);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL tq_drain[%0d]: got %h expected %h", k, obs_status(), exp_status());
            end
        end
        n_checks++;
        if ({count, tick_pend} !== {8'd8, 2'd0}) begin
            n_fail++;
            $display("FAIL tq_drained: got %0d/%0d expected 8/0", count, tick_pend);
        end
        clr_err = 1'b1;
        clk_step();
        clr_err = 1'b0;
        n_checks++;
        if (tick_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL tq_clr_err: got %b expected 0", tick_lost);
        end
    endtask

    task automatic test_divider();
        int c0;
        idle_inputs();
        tick_div = 24'd3;
        clk_step();
        c0 = m_count;
        tick_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL div_run[%0d]: got %h expected %h", k, obs_status(), exp_status());
            end
        end
        n_checks++;
        if ({count, tick_pend} !== {CNT_W'(c0 + 3), 2'd1}) begin
            n_fail++;
            $display("FAIL div_period: got %0d/%0d expected %0d/1", count, tick_pend, (c0 + 3) % M);
        end
        tick_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL div_hold[%0d]: got %h expected %h", k, obs_status(), exp_status());
            end
        end
        n_checks++;
        if (count !== CNT_W'(c0 + 4)) begin
            n_fail++;
            $display("FAIL div_hold_final: got %0d expected %0d", count, (c0 + 4) % M);
        end
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        tick_div = 24'd0;
        bus.req_valid = 4'b0001; bus.req_op = 8'b0000_0011; bus.req_data = 32'h0000_0005;
        clk_step();
        // CLEAR and a new tick on the same edge
        bus.req_op = 8'b0000_0010;
        tick_en = 1'b1;
        clk_step();
        n_checks++;
        if ({count, cnt_zero_p, tick_pend} !== {8'd0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL sim_clear_tick: got %0d/%b/%0d expected 0/1/1", count, cnt_zero_p, tick_pend);
        end
        idle_inputs();
        clk_step();
        n_checks++;
        if ({count, cnt_zero_p, tick_pend} !== {8'd1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL sim_tick_applied: got %0d/%b/%0d expected 1/0/0", count, cnt_zero_p, tick_pend);
        end
        bus.req_valid = 4'b0100; bus.req_op = 8'b0010_0000;
        clk_step();
        clk_step();
        n_checks++;
        if ({count, cnt_zero_p} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL sim_clear_at_zero: got %0d/%b expected 0/0", count, cnt_zero_p);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.req_valid = 4'($urandom);
            bus.req_op    = 8'($urandom);
            bus.req_data  = $urandom;
            tick_en       = 1'($urandom);
            tick_div      = 24'($urandom_range(0, 2));
            clr_err       = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if (bus.req_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_ready());
            end
            clk_step();
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got %h expected %h", k, obs_status(), exp_status());
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        tick_div  = '0;
        sys_rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        test_reset();
        test_round_robin();
        test_wrap();
        test_tick_queue();
        test_divider();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
